// File: rtl/fht_stage_ctrl.sv
// fht_stage_ctrl: read/twiddle/write address sequencer for one radix-2 FHT stage.
// Optional FHT_BITREV_EN: stage-0 read addresses are bit-reversed.
module fht_stage_ctrl #(
  parameter int ADDR_BIT  = 10,
  parameter int STAGE_BIT = 4
) (
  input  logic                  iCLK,
  input  logic                  iRESET,
  input  logic                  iSTART,
  input  logic [STAGE_BIT-1:0]  iSTAGE,
  output logic                  oBUSY,
  output logic                  oDONE,
  output logic                  oRD_EN_12,
  output logic [ADDR_BIT-1:0]   oRD_ADDR_1,
  output logic [ADDR_BIT-1:0]   oRD_ADDR_2,
  output logic [ADDR_BIT-2:0]   oROM_ADDR,
  output logic                  oRD_EN_0,
  output logic [ADDR_BIT-1:0]   oRD_ADDR_0,
  output logic                  oWR_EN,
  output logic [ADDR_BIT-1:0]   oWR_ADDR_0,
  output logic [ADDR_BIT-1:0]   oWR_ADDR_1
);
  localparam int RW = ADDR_BIT - 1;
  localparam logic [ADDR_BIT-1:0] ONE = ADDR_BIT'(1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t               state, state_nx;
  logic [ADDR_BIT-2:0]  b, b_nx;
  logic [STAGE_BIT-1:0] s, s_nx;
  logic [1:0]           fcnt, fcnt_nx;
  logic                 issue, done_nx;

  logic [ADDR_BIT-1:0]  bx, h, kk, base;
  logic [ADDR_BIT-1:0]  a0, a1, a2;
  logic [ADDR_BIT-1:0]  ra0, ra1, ra2;
  logic [RW-1:0]        rom;
  logic [31:0]          sh;

  logic [ADDR_BIT-1:0]  r0_1;
  logic [ADDR_BIT-1:0]  n0_1, n1_1, n0_2, n1_2, n0_3, n1_3;
  logic                 v3;

  always_comb begin
    state_nx = state;
    b_nx     = b;
    s_nx     = s;
    fcnt_nx  = fcnt;
    issue    = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (iSTART && (32'(iSTAGE) < ADDR_BIT)) begin
          state_nx = RUN;
          s_nx     = iSTAGE;
          b_nx     = '0;
        end
      end
      RUN: begin
        issue = 1'b1;
        b_nx  = b + 1'b1;
        if (&b) begin
          state_nx = FLUSH;
          fcnt_nx  = '0;
        end
      end
      FLUSH: begin
        fcnt_nx = fcnt + 2'd1;
        if (fcnt == 2'd3) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // butterfly b of stage s: group base plus offset k inside the half-span
  always_comb begin
    bx   = {1'b0, b};
    h    = ONE << s;
    kk   = bx & (h - ONE);
    base = ((bx >> s) << s) << 1;
    a0   = base + kk;
    a1   = base + h + kk;
    a2   = (kk == '0) ? (base + h) : (base + (h << 1) - kk);
    sh   = 32'(ADDR_BIT - 1) - 32'(s);
    rom  = RW'(kk << sh);
  end

`ifdef FHT_BITREV_EN
  function automatic logic [ADDR_BIT-1:0] rev(
    input logic [ADDR_BIT-1:0] x
  );
    logic [ADDR_BIT-1:0] r;
    r = '0;
    for (int i = 0; i < ADDR_BIT; i++)
      r[i] = x[ADDR_BIT-1-i];
    return r;
  endfunction

  always_comb begin
    ra0 = (s == '0) ? rev(a0) : a0;
    ra1 = (s == '0) ? rev(a1) : a1;
    ra2 = (s == '0) ? rev(a2) : a2;
  end
`else
  always_comb begin
    ra0 = a0;
    ra1 = a1;
    ra2 = a2;
  end
`endif

  // issue -> port-0 read -> butterfly -> write-back, one stage per clock
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state      <= IDLE;
      b          <= '0;
      s          <= '0;
      fcnt       <= '0;
      oBUSY      <= 1'b0;
      oDONE      <= 1'b0;
      oRD_EN_12  <= 1'b0;
      oRD_ADDR_1 <= '0;
      oRD_ADDR_2 <= '0;
      oROM_ADDR  <= '0;
      oRD_EN_0   <= 1'b0;
      oRD_ADDR_0 <= '0;
      oWR_EN     <= 1'b0;
      oWR_ADDR_0 <= '0;
      oWR_ADDR_1 <= '0;
      r0_1       <= '0;
      n0_1       <= '0;
      n1_1       <= '0;
      n0_2       <= '0;
      n1_2       <= '0;
      n0_3       <= '0;
      n1_3       <= '0;
      v3         <= 1'b0;
    end else begin
      state     <= state_nx;
      b         <= b_nx;
      s         <= s_nx;
      fcnt      <= fcnt_nx;
      oBUSY     <= (state != IDLE);
      oDONE     <= done_nx;
      oRD_EN_12 <= issue;
      oRD_EN_0  <= oRD_EN_12;
      v3        <= oRD_EN_0;
      oWR_EN    <= v3;
      if (issue) begin
        oRD_ADDR_1 <= ra1;
        oRD_ADDR_2 <= ra2;
        oROM_ADDR  <= rom;
        r0_1       <= ra0;
        n0_1       <= a0;
        n1_1       <= a1;
      end
      if (oRD_EN_12) begin
        oRD_ADDR_0 <= r0_1;
        n0_2       <= n0_1;
        n1_2       <= n1_1;
      end
      if (oRD_EN_0) begin
        n0_3 <= n0_2;
        n1_3 <= n1_2;
      end
      if (v3) begin
        oWR_ADDR_0 <= n0_3;
        oWR_ADDR_1 <= n1_3;
      end
    end
  end

endmodule

// File: tb/tb_fht_stage_ctrl.sv
// tb_fht_stage_ctrl: randomized runs of fht_stage_ctrl (N=8) against a
// group/offset reference model; honours FHT_BITREV_EN when defined.
module tb_fht_stage_ctrl;
  localparam int AB = 3;
  localparam int SB = 4;
  localparam int N  = 8;
  localparam int M  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [SB-1:0] stage;
  logic          busy, done;
  logic          en12, en0, wen;
  logic [AB-1:0] ra1, ra2, ra0, wa0, wa1;
  logic [AB-2:0] rom;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fht_stage_ctrl #(.ADDR_BIT(AB), .STAGE_BIT(SB)) dut (
    .iCLK      (clk),
    .iRESET    (rst),
    .iSTART    (start),
    .iSTAGE    (stage),
    .oBUSY     (busy),
    .oDONE     (done),
    .oRD_EN_12 (en12),
    .oRD_ADDR_1(ra1),
    .oRD_ADDR_2(ra2),
    .oROM_ADDR (rom),
    .oRD_EN_0  (en0),
    .oRD_ADDR_0(ra0),
    .oWR_EN    (wen),
    .oWR_ADDR_0(wa0),
    .oWR_ADDR_1(wa1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // butterfly b of stage st: group g of span 2h, offset k within it
  function automatic void model(input int st, input int bf,
                                output int a0, output int a1,
                                output int a2, output int ro);
    int h, g, k;
    h  = 2 ** st;
    g  = bf / h;
    k  = bf % h;
    a0 = g * 2 * h + k;
    a1 = a0 + h;
    a2 = (k == 0) ? a1 : g * 2 * h + 2 * h - k;
    ro = k * (N / 2) / h;
  endfunction

  function automatic int rev(input int x);
    int r, v;
    r = 0;
    v = x;
    for (int i = 0; i < AB; i++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  function automatic int rd(input int st, input int a);
`ifdef FHT_BITREV_EN
    return (st == 0) ? rev(a) : a;
`else
    return a;
`endif
  endfunction

  // one start at cycle 0; optional held start (rerun at 9) or reset
  task automatic run(input int st, input bit hold, input int rst_cyc);
    int last, r, s0, a0, a1, a2, ro;
    bit e12, e0, ew, eb, ed, zero;
    int x1, x2, xr, x0, w0, w1;
    stage = SB'(st);
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    last = hold ? 10 : 9;
    for (int c = 1; c <= last; c++) begin
      tick();
      rst = (c == rst_cyc);
      {e12, e0, ew, eb, ed} = '0;
      {x1, x2, xr, x0, w0, w1} = '0;
      for (int j = 0; j < (hold ? 2 : 1); j++) begin
        s0 = j * (M + 5);
        r  = c - s0;
        if (r >= 1 && r <= M) begin
          e12 = 1;
          model(st, r - 1, a0, a1, a2, ro);
          x1 = rd(st, a1);
          x2 = rd(st, a2);
          xr = ro;
        end
        if (r >= 2 && r <= M + 1) begin
          e0 = 1;
          model(st, r - 2, a0, a1, a2, ro);
          x0 = rd(st, a0);
        end
        if (r >= 4 && r <= M + 3) begin
          ew = 1;
          model(st, r - 4, a0, a1, a2, ro);
          w0 = a0;
          w1 = a1;
        end
        if (r >= 1 && r <= M + 4) eb = 1;
        if (r == M + 4) ed = 1;
      end
      zero = (rst_cyc > 0) && (c > rst_cyc);
      if (zero) begin
        {e12, e0, ew, eb, ed} = '0;
        chk("rst_a1", ra1, 0);
        chk("rst_a2", ra2, 0);
        chk("rst_rom", rom, 0);
        chk("rst_a0", ra0, 0);
        chk("rst_w0", wa0, 0);
        chk("rst_w1", wa1, 0);
      end
      chk("en12", en12, e12);
      chk("en0", en0, e0);
      chk("wr_en", wen, ew);
      chk("busy", busy, eb);
      chk("done", done, ed);
      if (e12) begin
        chk("rd_a1", ra1, x1);
        chk("rd_a2", ra2, x2);
        chk("rom", rom, xr);
      end
      if (e0) chk("rd_a0", ra0, x0);
      if (ew) begin
        chk("wr_a0", wa0, w0);
        chk("wr_a1", wa1, w1);
      end
      if (st == 2 && c == 2 && rst_cyc == 0) begin
        chk("s2_a2_lit", ra2, 7);
        chk("s2_rom_lit", rom, 1);
        chk("s2_a0_lit", ra0, 0);
      end
    end
    rst   = 1'b0;
    start = 1'b0;
    if (hold) begin
      repeat (12) tick();
      chk("hold_idle", busy, 0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stage = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en12", en12, 0);
    chk("rst_en0", en0, 0);
    chk("rst_wen", wen, 0);
    chk("rst_ra1", ra1, 0);
    chk("rst_ra2", ra2, 0);
    chk("rst_rom0", rom, 0);
    chk("rst_ra0", ra0, 0);
    chk("rst_wa0", wa0, 0);
    chk("rst_wa1", wa1, 0);

    run(2, 1'b0, 0);
    run(1, 1'b0, 0);
    run(0, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      run(int'($urandom_range(0, 2)), 1'b0, 0);
    end

    // out-of-range stage never starts
    stage = SB'(3 + $urandom_range(0, 12));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("bad_busy", busy, 0);
      chk("bad_en12", en12, 0);
      chk("bad_en0", en0, 0);
      chk("bad_wen", wen, 0);
      chk("bad_done", done, 0);
    end

    run(int'($urandom_range(0, 2)), 1'b1, 0);
    run(int'($urandom_range(0, 2)), 1'b0, 3);
    tick();
    run(int'($urandom_range(0, 2)), 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
